// File: rtl/pwm_medidor.sv
// PWM receiver: measures high time and rise-to-rise period of pwm_in in clk cycles.
// Optional glitch filter enabled by defining PWM_MEDIDOR_GLITCH_FILTER_EN.
module pwm_medidor #(
  parameter int R    = 8,
  parameter int W    = 16,
  parameter int FILT = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pwm_in,
  output logic [W-1:0] high_time,
  output logic [W-1:0] period,
  output logic         valid,
  output logic         timeout,
  output logic         level
);

  localparam logic [W-1:0] MAX = '1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  // A nominal generator period (2^R) must fit in the counter, and the filter needs FILT >= 1.
  if (R >= W || FILT < 1) begin : g_bad_config
  end

  logic sync1, s, v1, s_ok;
  logic f, f_ok;
  logic s_d, d_ok;
  logic rise, fall;
  state_t state;
  logic [W-1:0] cnt, hi_lat;

  // The valid bits ride alongside the synchronizer so the first real sample after
  // reset seeds the edge detector instead of looking like a rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      v1    <= 1'b0;
      s_ok  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the pre-edge value, so this chain really is two stages.
      sync1 <= pwm_in;
      s     <= sync1;
      v1    <= 1'b1;
      s_ok  <= v1;
    end
  end

`ifdef PWM_MEDIDOR_GLITCH_FILTER_EN
  localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;
  logic [FW-1:0] fcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f    <= 1'b0;
      f_ok <= 1'b0;
      fcnt <= '0;
    end else begin
      f_ok <= s_ok;
      if (s_ok && !f_ok) begin
        f    <= s;
        fcnt <= '0;
      end else if (s != f) begin
        if (fcnt == FW'(FILT - 1)) begin
          f    <= s;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end
`else
  assign f    = s;
  assign f_ok = s_ok;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_d  <= 1'b0;
      d_ok <= 1'b0;
    end else begin
      s_d  <= f;
      d_ok <= f_ok;
    end
  end

  assign rise  = f & ~s_d & d_ok;
  assign fall  = ~f & s_d & d_ok;
  assign level = f;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_lat    <= '0;
      high_time <= '0;
      period    <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= 1'b0;
      cnt   <= (cnt == MAX) ? cnt : cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (rise) begin
            cnt   <= W'(1);
            state <= HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            hi_lat <= cnt;
            state  <= LOW;
          end else if (cnt == MAX) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end
        end
        LOW: begin
          // An edge on the saturation cycle still yields a measurement of MAX.
          if (rise) begin
            period    <= cnt;
            high_time <= hi_lat;
            valid     <= 1'b1;
            timeout   <= 1'b0;
            cnt       <= W'(1);
            state     <= HIGH;
          end else if (cnt == MAX) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_medidor.sv
// Randomized self-checking bench for pwm_medidor: a segment-level model of the
// pin waveform predicts every measurement, its arrival cycle, and the timeout.
module tb_pwm_medidor;

  localparam int W    = 16;
  localparam int FILT = 3;
  localparam int MAXC = 65535;
`ifdef PWM_MEDIDOR_GLITCH_FILTER_EN
  localparam int LAT     = 3 + FILT;
  localparam bit FILT_ON = 1'b1;
`else
  localparam int LAT     = 3;
  localparam bit FILT_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         pwm_in;
  logic [W-1:0] high_time, period;
  logic         valid, timeout, level;

  pwm_medidor #(.R(8), .W(W), .FILT(FILT)) dut (
    .clk       (clk),
    .reset     (reset),
    .pwm_in    (pwm_in),
    .high_time (high_time),
    .period    (period),
    .valid     (valid),
    .timeout   (timeout),
    .level     (level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model: a measurement completes at every rise that follows a tracked rise and fall.
  typedef struct {
    int hi;
    int per;
    int due;
  } meas_t;

  meas_t exp_q[$];
  bit    m_lvl, m_have_rise, m_have_fall;
  int    m_rise_t, m_fall_t;

  task automatic model_reset();
    m_lvl       = pwm_in;
    m_have_rise = 1'b0;
    m_have_fall = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_timeout();
    m_have_rise = 1'b0;
    m_have_fall = 1'b0;
  endtask

  task automatic model_edge(input bit lvl, input int t);
    meas_t m;
    if (lvl == m_lvl) return;
    m_lvl = lvl;
    if (lvl) begin
      if (m_have_rise && m_have_fall) begin
        m.hi  = m_fall_t - m_rise_t;
        m.per = t - m_rise_t;
        m.due = t + LAT - 1;
        exp_q.push_back(m);
      end
      m_rise_t    = t;
      m_have_rise = 1'b1;
      m_have_fall = 1'b0;
    end else if (m_have_rise) begin
      m_fall_t    = t;
      m_have_fall = 1'b1;
    end
  endtask

  // Drive lvl for n cycles; with the filter on, a short opposite pulse is invisible.
  task automatic seg(input bit lvl, input int n);
    pwm_in = lvl;
    if (!(FILT_ON && n < FILT && lvl != m_lvl)) model_edge(lvl, cyc + 1);
    repeat (n) @(negedge clk);
  endtask

  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (valid) begin
        meas_t m;
        check("valid_spacing", prev_valid, 0);
        check("timeout_clear_on_valid", timeout, 0);
        check("valid_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          m = exp_q.pop_front();
          check("high_time", high_time, m.hi);
          check("period", period, m.per);
          check("valid_cycle", cyc, m.due);
        end
      end
      prev_valid = valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  int rt;

  initial begin
    reset  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);

    // Line toggling while reset is held: nothing may come out.
    for (int i = 0; i < 20; i++) begin
      pwm_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (i % 4 == 3) check("rst_valid", valid, 0);
    end
    check("rst_high_time", high_time, 0);
    check("rst_period", period, 0);
    check("rst_timeout", timeout, 0);
    check("rst_level", level, 0);
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    seg(0, 10);
    check("post_rst_period", period, 0);

    // Steady 25% duty.
    for (int k = 0; k < 6; k++) begin
      seg(1, 64);
      seg(0, 192);
    end
    check("steady_timeout", timeout, 0);
    check("steady_high_time", high_time, 64);
    check("steady_period", period, 256);

    // Extremes.
    for (int k = 0; k < 3; k++) begin
      seg(1, 1);
      seg(0, 255);
    end
    for (int k = 0; k < 3; k++) begin
      seg(1, 255);
      seg(0, 1);
    end
    seg(1, 64);
    seg(0, 192);

    // Random high/low durations.
    for (int k = 0; k < 8; k++) begin
      seg(1, $urandom_range(4, 300));
      seg(0, $urandom_range(4, 300));
    end

    // Glitch inside the low phase.
    seg(1, 64);
    seg(0, 192);
    seg(1, 64);
    seg(0, 50);
    seg(1, 2);
    seg(0, 140);
    seg(1, 64);
    seg(0, 192);
    seg(1, 64);
    seg(0, 192);

    // Stuck high after valid measurements.
    seg(1, 64);
    seg(0, 192);
    rt = cyc + 1;
    seg(1, 10);
    while (cyc < rt + LAT - 1 + MAXC - 1) @(negedge clk);
    check("timeout_before_max", timeout, 0);
    @(negedge clk);
    check("timeout_at_max", timeout, 1);
    model_timeout();
    repeat (5) @(negedge clk);
    check("stuck_level", level, 1);
    check("stuck_high_time_kept", high_time, 64);
    check("stuck_period_kept", period, 256);
    seg(0, 192);
    seg(1, 64);
    seg(0, 192);
    check("timeout_held", timeout, 1);
    seg(1, 64);
    seg(0, 192);
    check("timeout_cleared", timeout, 0);

    // Reset in the middle of a high phase.
    seg(1, 64);
    seg(0, 192);
    seg(1, 30);
    reset = 1'b0;
    #1;
    check("midrst_high_time", high_time, 0);
    check("midrst_period", period, 0);
    check("midrst_valid", valid, 0);
    check("midrst_timeout", timeout, 0);
    check("midrst_level", level, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    model_reset();
    seg(1, 34);
    seg(0, 192);
    check("midrst_no_partial", period, 0);
    seg(1, 64);
    seg(0, 192);
    seg(1, 64);
    seg(0, 192);
    seg(1, 64);
    seg(0, 20);

    check("pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
